chip8_sound_timer: RTL and testbench
====================================

Name: chip8_sound_timer

Overview:
Upstream control stage for the CHIP-8 audio path. Holds the CHIP-8 sound timer (ST) register, loaded by the CPU (FX18) and decremented at 60 Hz. Produces the tone gate (active_out) and a 3-bit volume envelope (env_vol_out), which drive the active_in and vol_in inputs of chip8_audio. Also exports the shared 60 Hz tick for the delay timer.

Parameters:
CLK_HZ, 100_000_000, frequency of clk_in in Hz.
TICK_HZ, 60, timer decrement rate; prescaler divisor DIV = CLK_HZ/TICK_HZ, integer, must be >= 2.
ENV_STEP_CYCLES, 65536, clk_in cycles per envelope step; must be >= 1.

Ports:
clk_in  input  1  system clock; the only clock.
rst_n_in  input  1  reset; asynchronous, active-low.
st_load_in  input  1  single-cycle strobe that loads ST from st_data_in.
st_data_in  input  8  value to load into ST.
vol_target_in  input  3  sustain volume, 0..7.
st_out  output  8  current ST value, for CPU readback.
tick_60_out  output  1  single-cycle pulse every DIV cycles.
active_out  output  1  tone gate to the audio block.
env_vol_out  output  3  envelope volume to the audio block.

Behaviour:
- Reset (rst_n_in low, asynchronous): prescaler=0, ST=0, state=IDLE, step counter=0. Outputs: st_out=0, tick_60_out=0, active_out=0, env_vol_out=0.
- Prescaler:
  - Free-running count 0..DIV-1; wraps to 0 after DIV-1.
  - tick_60_out is registered and pulses high on the cycle after the count equals DIV-1.
  - First pulse comes DIV cycles after reset release.
  - Loads never reset the prescaler.
- ST register:
  - Load: if st_load_in is high in cycle N, ST=st_data_in from cycle N+1.
  - Decrement: on a tick_60_out cycle with no load, ST decrements by 1 if ST != 0. ST saturates at 0 and never wraps.
  - Simultaneous load and tick: the load wins and no decrement happens that cycle.
  - st_out is ST, registered.
- Envelope FSM (states IDLE, ATTACK, SUSTAIN, RELEASE), evaluated on registered ST:
  - Step counter: counts 0..ENV_STEP_CYCLES-1. A "step" is the cycle the counter reaches ENV_STEP_CYCLES-1. The counter clears on every state change.
  - IDLE: env=0, active_out=0. ST != 0 -> ATTACK.
  - ATTACK: active_out=1. Each step, env+1.
    - env >= vol_target_in -> SUSTAIN (checked every cycle; target 0 -> SUSTAIN on the next cycle with env=0).
    - ST==0 -> RELEASE, with priority over the SUSTAIN transition.
  - SUSTAIN: active_out=1. Each step, env moves 1 toward vol_target_in (up or down). ST==0 -> RELEASE.
  - RELEASE: active_out=1. Each step, env-1.
    - env==0 -> IDLE; active_out falls with the state change.
    - ST != 0 (reload during release) -> ATTACK, starting from the current env with no reset to 0.
  - env never goes above 7 or below 0.
- Latency:
  - Load strobe at cycle N: st_out at N+1; active_out=1 at N+2.
  - First env increment ENV_STEP_CYCLES cycles after ATTACK entry.
  - active_out stays high after ST reaches 0 until release finishes, giving click-free tails.
- Reset mid-operation: all state clears immediately (asynchronous); the next reset-release behaves like power-up.

Optional Feature:
CHIP8_VIP_MIN_BEEP_EN:
- Defined: COSMAC VIP quirk. A load of st_data_in==1 stores 0, so no tone or envelope is produced. All other values load normally.
- Undefined: a value of 1 loads as 1 and beeps for up to one tick.

Test Plan:
Use CLK_HZ=600, TICK_HZ=60 (DIV=10) and ENV_STEP_CYCLES=4 throughout.
- Reset release, no loads for 35 cycles -> tick_60_out pulses at cycles 10, 20, 30; st_out=0; active_out=0.
- Load 3 with vol_target_in=2 -> st_out 3,2,1,0 on successive ticks. active_out high 2 cycles after the strobe. env 0->1->2 at 4-cycle steps, then SUSTAIN. After ST=0: env 2->1->0, then active_out=0.
- Load 5 on the same cycle as a tick pulse -> st_out=5 next cycle with no decrement. Load 0 while ST=4 -> st_out=0 and RELEASE begins.
- Reload 2 during RELEASE at env=1 -> ATTACK from env=1, reaching 2 one step later.
- Change vol_target_in from 6 to 3 in SUSTAIN at env=6 -> env steps 5, 4, 3 and holds. Pull rst_n_in low mid-attack -> all outputs 0 asynchronously.
- Load 1: with CHIP8_VIP_MIN_BEEP_EN, st_out=0 and active_out stays 0. Without it, st_out=1 and active_out rises, then ST clears at the next tick.

Source files
------------

// File: rtl/chip8_sound_timer.sv
// chip8_sound_timer
//
// Front end of the CHIP-8 audio path. It holds the sound timer (ST), which the
// CPU loads with FX18 and which counts down at 60 Hz. While ST is non-zero the
// block opens a tone gate and runs a volume envelope (attack/sustain/release)
// for chip8_audio. It also exports the 60 Hz tick that the delay timer shares.
//
// Ports
//   clk_in         system clock; the only clock
//   rst_n_in       asynchronous active-low reset
//   st_load_in     single-cycle strobe that loads ST from st_data_in
//   st_data_in     [7:0] value to load into ST
//   vol_target_in  [2:0] sustain volume
//   st_out         [7:0] registered ST value, for CPU readback
//   tick_60_out    single-cycle pulse every CLK_HZ/TICK_HZ cycles
//   active_out     tone gate, drives chip8_audio active_in
//   env_vol_out    [2:0] envelope volume, drives chip8_audio vol_in
//
// Build option
//   CHIP8_VIP_MIN_BEEP_EN  when defined, a load of 1 stores 0, so the tone is
//                          suppressed (COSMAC VIP behaviour).
//
// Envelope states
//   state   | meaning
//   IDLE    | no tone, env held at 0, waiting for ST != 0
//   ATTACK  | tone on, env rises one per step until it reaches the target
//   SUSTAIN | tone on, env tracks vol_target_in one per step
//   RELEASE | ST expired, tone on while env falls one per step to 0

module chip8_sound_timer #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int TICK_HZ         = 60,
    parameter int ENV_STEP_CYCLES = 65536
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       st_load_in,
    input  logic [7:0] st_data_in,
    input  logic [2:0] vol_target_in,
    output logic [7:0] st_out,
    output logic       tick_60_out,
    output logic       active_out,
    output logic [2:0] env_vol_out
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = (ENV_STEP_CYCLES > 1) ? $clog2(ENV_STEP_CYCLES) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(ENV_STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } state_t;

    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q, tick_d;
    logic [7:0]    st_q, st_d;
    logic [7:0]    load_val;
    state_t        state_q, state_d;
    logic [2:0]    env_q, env_d;
    logic [SW-1:0] step_cnt_q, step_cnt_d;
    logic          step;

    // Prescaler and ST register

    always_comb begin
        pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        tick_d = (pre_q == PRE_LAST);
    end

`ifdef CHIP8_VIP_MIN_BEEP_EN
    always_comb begin
        load_val = (st_data_in == 8'd1) ? 8'd0 : st_data_in;
    end
`else
    always_comb begin
        load_val = st_data_in;
    end
`endif

    // A load in the same cycle as a tick takes precedence over the decrement.
    always_comb begin
        st_d = st_q;
        if (st_load_in) begin
            st_d = load_val;
        end else if (tick_q && (st_q != 8'd0)) begin
            st_d = st_q - 8'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
            st_q   <= 8'd0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
            st_q   <= st_d;
        end
    end

    // Envelope FSM: state register

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            env_q      <= 3'd0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            env_q      <= env_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    // Envelope FSM: next state

    assign step = (step_cnt_q == STEP_LAST);

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        case (state_q)
            IDLE: begin
                env_d = 3'd0;
                if (st_q != 8'd0) state_d = ATTACK;
            end
            ATTACK: begin
                // Expiry wins over reaching the target.
                if (st_q == 8'd0) begin
                    state_d = RELEASE;
                end else if (env_q >= vol_target_in) begin
                    state_d = SUSTAIN;
                end else if (step && (env_q != 3'd7)) begin
                    env_d = env_q + 3'd1;
                end
            end
            SUSTAIN: begin
                if (st_q == 8'd0) begin
                    state_d = RELEASE;
                end else if (step) begin
                    if (env_q < vol_target_in)      env_d = env_q + 3'd1;
                    else if (env_q > vol_target_in) env_d = env_q - 3'd1;
                end
            end
            RELEASE: begin
                // A reload re-attacks from the current level so there is no dip.
                if (st_q != 8'd0) begin
                    state_d = ATTACK;
                end else if (env_q == 3'd0) begin
                    state_d = IDLE;
                end else if (step) begin
                    env_d = env_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                env_d   = 3'd0;
            end
        endcase

        // Step timing restarts from zero in every newly entered state.
        if (state_d != state_q) begin
            step_cnt_d = '0;
        end else begin
            step_cnt_d = step ? '0 : step_cnt_q + 1'b1;
        end
    end

    // Envelope FSM: outputs

    always_comb begin
        active_out  = (state_q != IDLE);
        env_vol_out = env_q;
        st_out      = st_q;
        tick_60_out = tick_q;
    end

endmodule

// File: tb/tb_chip8_sound_timer.sv
module tb_chip8_sound_timer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       st_load;
    logic [7:0] st_data;
    logic [2:0] vol_target;
    logic [7:0] st_out;
    logic       tick_60;
    logic       active;
    logic [2:0] env_vol;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    chip8_sound_timer #(
        .CLK_HZ(600),
        .TICK_HZ(60),
        .ENV_STEP_CYCLES(4)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .st_load_in(st_load),
        .st_data_in(st_data),
        .vol_target_in(vol_target),
        .st_out(st_out),
        .tick_60_out(tick_60),
        .active_out(active),
        .env_vol_out(env_vol)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        rst_n      = 1'b0;
        st_load    = 1'b0;
        st_data    = 8'd0;
        vol_target = 3'd2;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_st", st_out, 8'd0);
        chk("reset_tick", 8'(tick_60), 8'd0);
        chk("reset_active", 8'(active), 8'd0);
        chk("reset_env", 8'(env_vol), 8'd0);

        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;

        for (int c = 1; c <= 35; c++) begin
            step();
            chk("idle_tick", 8'(tick_60), (cyc % 10 == 0) ? 8'd1 : 8'd0);
            chk("idle_st", st_out, 8'd0);
            chk("idle_active", 8'(active), 8'd0);
        end

        // Load 3, target 2
        st_load = 1'b1; st_data = 8'd3;
        run_to(36); st_load = 1'b0;
        chk("l3_st", st_out, 8'd3);
        chk("l3_active_n1", 8'(active), 8'd0);
        run_to(37);
        chk("l3_active_n2", 8'(active), 8'd1);
        chk("l3_env0", 8'(env_vol), 8'd0);
        run_to(40);
        chk("l3_env_pre_step", 8'(env_vol), 8'd0);
        chk("l3_tick40", 8'(tick_60), 8'd1);
        run_to(41);
        chk("l3_env1", 8'(env_vol), 8'd1);
        chk("l3_st2", st_out, 8'd2);
        run_to(45);
        chk("l3_env2", 8'(env_vol), 8'd2);
        run_to(51);
        chk("l3_st1", st_out, 8'd1);
        run_to(61);
        chk("l3_st0", st_out, 8'd0);
        chk("l3_tail_active", 8'(active), 8'd1);
        chk("l3_tail_env2", 8'(env_vol), 8'd2);
        run_to(65);
        chk("rel_env2", 8'(env_vol), 8'd2);
        run_to(66);
        chk("rel_env1", 8'(env_vol), 8'd1);
        run_to(70);
        chk("rel_env0", 8'(env_vol), 8'd0);
        chk("rel_active", 8'(active), 8'd1);
        run_to(71);
        chk("rel_done_active", 8'(active), 8'd0);

        // Load coinciding with a tick
        run_to(80);
        chk("tick80", 8'(tick_60), 8'd1);
        st_load = 1'b1; st_data = 8'd5;
        run_to(81); st_load = 1'b0;
        chk("load_vs_tick_st", st_out, 8'd5);
        run_to(91);
        chk("st4", st_out, 8'd4);
        st_load = 1'b1; st_data = 8'd0;
        run_to(92); st_load = 1'b0;
        chk("load0_st", st_out, 8'd0);
        chk("load0_active", 8'(active), 8'd1);
        chk("load0_env", 8'(env_vol), 8'd2);
        run_to(96);
        chk("rel2_env2", 8'(env_vol), 8'd2);
        run_to(97);
        chk("rel2_env1", 8'(env_vol), 8'd1);

        // Reload during release at env 1
        st_load = 1'b1; st_data = 8'd2;
        run_to(98); st_load = 1'b0;
        chk("reload_st", st_out, 8'd2);
        run_to(99);
        chk("reattack_env", 8'(env_vol), 8'd1);
        chk("reattack_active", 8'(active), 8'd1);
        run_to(102);
        chk("reattack_hold", 8'(env_vol), 8'd1);
        run_to(103);
        chk("reattack_env2", 8'(env_vol), 8'd2);

        // Sustain tracking: raise to 6, then drop to 3
        run_to(104);
        vol_target = 3'd6; st_load = 1'b1; st_data = 8'd200;
        run_to(105); st_load = 1'b0;
        chk("st200", st_out, 8'd200);
        run_to(108);
        chk("sus_env3", 8'(env_vol), 8'd3);
        run_to(120);
        chk("sus_env6", 8'(env_vol), 8'd6);
        vol_target = 3'd3;
        run_to(124);
        chk("sus_down5", 8'(env_vol), 8'd5);
        run_to(128);
        chk("sus_down4", 8'(env_vol), 8'd4);
        run_to(132);
        chk("sus_down3", 8'(env_vol), 8'd3);
        run_to(140);
        chk("sus_hold3", 8'(env_vol), 8'd3);
        chk("st197", st_out, 8'd197);
        chk("tick140", 8'(tick_60), 8'd1);
        st_load = 1'b1; st_data = 8'd0;
        run_to(141); st_load = 1'b0;
        chk("load0_vs_tick", st_out, 8'd0);
        run_to(154);
        chk("rel3_env0", 8'(env_vol), 8'd0);
        chk("rel3_active", 8'(active), 8'd1);
        run_to(155);
        chk("rel3_idle", 8'(active), 8'd0);

        // Async reset mid-attack
        st_load = 1'b1; st_data = 8'd3;
        run_to(156); st_load = 1'b0;
        run_to(157);
        chk("att_active", 8'(active), 8'd1);
        run_to(161);
        chk("att_env1", 8'(env_vol), 8'd1);
        chk("att_st2", st_out, 8'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_st", st_out, 8'd0);
        chk("async_rst_active", 8'(active), 8'd0);
        chk("async_rst_env", 8'(env_vol), 8'd0);
        chk("async_rst_tick", 8'(tick_60), 8'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;

        // Load of 1
        run_to(3);
        st_load = 1'b1; st_data = 8'd1;
        run_to(4); st_load = 1'b0;
`ifdef CHIP8_VIP_MIN_BEEP_EN
        chk("vip_st", st_out, 8'd0);
        run_to(5);
        chk("vip_active", 8'(active), 8'd0);
        run_to(10);
        chk("vip_active_late", 8'(active), 8'd0);
        chk("vip_env", 8'(env_vol), 8'd0);
        chk("post_rst_tick10", 8'(tick_60), 8'd1);
`else
        chk("one_st", st_out, 8'd1);
        run_to(5);
        chk("one_active", 8'(active), 8'd1);
        run_to(10);
        chk("post_rst_tick10", 8'(tick_60), 8'd1);
        chk("one_st_pre_tick", st_out, 8'd1);
        run_to(11);
        chk("one_st_cleared", st_out, 8'd0);
        chk("one_active_tail", 8'(active), 8'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
